// File: rtl/corelet_pkg.sv
// Shared types for the corelet tile controller.
// FSM state encoding and instruction-word bit positions.
package corelet_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_FILL = 3'd1,
    W_LOAD = 3'd2,
    W_WAIT = 3'd3,
    X_FILL = 3'd4,
    X_EXEC = 3'd5,
    DRAIN  = 3'd6,
    DONE   = 3'd7
  } state_e;

  localparam int INST_W = 34;
  localparam int CNT_W  = 8;

  localparam int KLOAD = 0;
  localparam int EXEC  = 1;
  localparam int L0WR  = 2;
  localparam int L0RD  = 3;
  localparam int OFRD  = 6;

endpackage

// File: rtl/corelet_ctrl.sv
// Corelet tile sequencer: weight fill/load, activation
// fill/execute and OFIFO-to-psum drain, one shared counter.
module corelet_ctrl
  import corelet_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int aw      = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [6:0]             cfg_nvec,
  input  logic [aw-1:0]          cfg_w_base,
  input  logic [aw-1:0]          cfg_x_base,
  input  logic [aw-1:0]          cfg_p_base,
  output logic                   busy,
  output logic                   done,
  output logic                   act_en,
  output logic [aw-1:0]          act_addr,
  input  logic [row*bw-1:0]      act_rdata,
  output logic [INST_W-1:0]      inst_q,
  output logic [row*bw-1:0]      l0_input,
  input  logic                   ofifo_valid,
  input  logic [col*psum_bw-1:0] ofifo_output,
  output logic                   psum_wen,
  output logic [aw-1:0]          psum_addr,
  output logic [col*psum_bw-1:0] psum_wdata
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       wr_q, wr_d;
  logic [6:0]       nvec_q;
  logic [aw-1:0]    w_base_q;
  logic [aw-1:0]    x_base_q;
  logic [aw-1:0]    p_base_q;

  logic             take;
  logic             fill;
  logic             drain_act;
  logic             pop;
  logic [CNT_W-1:0] nvec_c;
  logic [CNT_W-1:0] lim;
  logic [aw-1:0]    base;

  assign take   = (state_q == IDLE) && start;
  assign nvec_c = {{(CNT_W-7){1'b0}}, nvec_q};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (start) state_d = W_FILL;
      W_FILL: if (cnt_q == CNT_W'(row)) state_d = W_LOAD;
      W_LOAD: if (cnt_q == CNT_W'(row - 1)) state_d = W_WAIT;
      W_WAIT: begin
        if (cnt_q == CNT_W'(col - 1))
          state_d = (nvec_q == 7'd0) ? DONE : X_FILL;
      end
      X_FILL: if (cnt_q == nvec_c) state_d = X_EXEC;
      X_EXEC: if (cnt_q == nvec_c - 1'b1) state_d = DRAIN;
      DRAIN:  if (wr_q == nvec_q) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (state_d != state_q || state_q == IDLE)
      cnt_d = '0;
  end

  // Fill phases share one address/data path; W vs X picks base and length.
  assign fill = (state_q == W_FILL) || (state_q == X_FILL);
  assign base = (state_q == W_FILL) ? w_base_q : x_base_q;
  assign lim  = (state_q == W_FILL) ? CNT_W'(row) : nvec_c;

  assign drain_act = (state_q == X_EXEC) || (state_q == DRAIN);
  assign pop = drain_act && (wr_q < nvec_q) && ofifo_valid;

  always_comb begin
    wr_d = wr_q;
    if (take)
      wr_d = '0;
    else if (pop)
      wr_d = wr_q + 1'b1;
  end

  always_comb begin
    act_en   = fill && (cnt_q < lim);
    act_addr = '0;
    if (act_en)
      act_addr = base + aw'(cnt_q);
  end

  always_comb begin
    inst_q   = '0;
    l0_input = '0;
    unique case (1'b1)
      fill: begin
        if (cnt_q != '0) begin
          inst_q[L0WR] = 1'b1;
          l0_input     = act_rdata;
        end
      end
      (state_q == W_LOAD): begin
        inst_q[L0RD]  = 1'b1;
        inst_q[KLOAD] = 1'b1;
      end
      (state_q == X_EXEC): begin
        inst_q[L0RD] = 1'b1;
        inst_q[EXEC] = 1'b1;
      end
      default: ;
    endcase
    inst_q[OFRD] = pop;
  end

  assign psum_wen   = pop;
  assign psum_wdata = drain_act ? ofifo_output : '0;
  assign psum_addr  = drain_act ? p_base_q + aw'(wr_q) : '0;

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nvec_q   <= '0;
      w_base_q <= '0;
      x_base_q <= '0;
      p_base_q <= '0;
    end else if (take) begin
      nvec_q   <= cfg_nvec;
      w_base_q <= cfg_w_base;
      x_base_q <= cfg_x_base;
      p_base_q <= cfg_p_base;
    end
  end

endmodule

// File: tb/tb_corelet_ctrl.sv
// Self-checking bench for corelet_ctrl: tile table plus
// reset-abort, back-pressure and ignored-start sequences.
module tb_corelet_ctrl;

  localparam int AW = 11;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [6:0]   cfg_nvec = '0;
  logic [10:0]  cfg_w_base = '0;
  logic [10:0]  cfg_x_base = '0;
  logic [10:0]  cfg_p_base = '0;
  logic         busy, done, act_en;
  logic [10:0]  act_addr;
  logic [31:0]  act_rdata = '0;
  logic [33:0]  inst_q;
  logic [31:0]  l0_input;
  logic         ofifo_valid = 1'b0;
  logic [127:0] ofifo_output = '0;
  logic         psum_wen;
  logic [10:0]  psum_addr;
  logic [127:0] psum_wdata;

  corelet_ctrl #(
    .bw(4), .psum_bw(16), .row(8), .col(8), .aw(AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_nvec(cfg_nvec), .cfg_w_base(cfg_w_base),
    .cfg_x_base(cfg_x_base), .cfg_p_base(cfg_p_base),
    .busy(busy), .done(done), .act_en(act_en),
    .act_addr(act_addr), .act_rdata(act_rdata),
    .inst_q(inst_q), .l0_input(l0_input),
    .ofifo_valid(ofifo_valid), .ofifo_output(ofifo_output),
    .psum_wen(psum_wen), .psum_addr(psum_addr),
    .psum_wdata(psum_wdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [10:0] a);
    logic [31:0] w;
    for (int k = 0; k < 8; k++) w[k*4 +: 4] = a[3:0] + 4'(k);
    return w;
  endfunction

  function automatic logic [127:0] prow(input int r);
    logic [127:0] d;
    for (int j = 0; j < 8; j++) d[j*16 +: 16] = 16'h1000 + 16'(r * 16 + j);
    return d;
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  always @(posedge clk) act_rdata <= act_en ? word(act_addr) : '0;

  // Monitor state: cleared whenever a new tile id is announced.
  int tile_id = 0;
  int seen_id = 0;
  logic [10:0]  act_log[$];
  logic [31:0]  l0_log[$];
  logic [33:0]  inst_log[$];
  logic [10:0]  pa_log[$];
  logic [127:0] pd_log[$];
  int done_cnt = 0, busy_cnt = 0, exec_seen = 0, popped = 0;
  int bad_inst = 0, wen_bad = 0;
  bit hold = 1'b0;
  bit gap = 1'b0;
  int cyc = 0;

  always @(negedge clk) begin
    if (tile_id != seen_id) begin
      act_log.delete(); l0_log.delete(); inst_log.delete();
      pa_log.delete(); pd_log.delete();
      done_cnt = 0; busy_cnt = 0; exec_seen = 0; popped = 0;
      bad_inst = 0; wen_bad = 0;
      seen_id = tile_id;
    end
    if (busy) begin
      busy_cnt++;
      inst_log.push_back(inst_q);
    end
    if (act_en) act_log.push_back(act_addr);
    if (inst_q[2]) l0_log.push_back(l0_input);
    if (psum_wen) begin
      pa_log.push_back(psum_addr);
      pd_log.push_back(psum_wdata);
    end
    if (done) done_cnt++;
    if (inst_q[1]) exec_seen++;
    if (inst_q[6]) popped++;
    if ((inst_q & ~34'h4F) != 34'h0) bad_inst++;
    if (psum_wen != inst_q[6]) wen_bad++;
  end

  // OFIFO model: one row becomes available per execute cycle.
  always @(posedge clk) begin
    cyc++;
    #1;
    ofifo_output = prow(popped);
    ofifo_valid = !hold && (exec_seen > popped) && (!gap || cyc[0]);
  end

  task automatic start_tile(input logic [6:0] n, input logic [10:0] wb,
                            input logic [10:0] xb, input logic [10:0] pb);
    tile_id++;
    cfg_nvec = n; cfg_w_base = wb; cfg_x_base = xb; cfg_p_base = pb;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int k;
    k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk({nm, "_done_seen"}, 128'(done_cnt != 0), 1);
    @(negedge clk); #1;
    chk({nm, "_idle_after"}, 128'(busy), 0);
  endtask

  task automatic check_tile(input string nm, input int n, input logic [10:0] wb,
                            input logic [10:0] xb, input logic [10:0] pb,
                            input int eb);
    logic [10:0] ea;
    int e1, e2, e3, kl;
    e1 = 0; e2 = 0; e3 = 0; kl = 0;
    chk({nm, "_act_cnt"}, act_log.size(), 8 + n);
    chk({nm, "_l0_cnt"}, l0_log.size(), 8 + n);
    for (int i = 0; i < act_log.size(); i++) begin
      ea = (i < 8) ? wb + 11'(i) : xb + 11'(i - 8);
      if (act_log[i] !== ea) e1++;
      if (i < l0_log.size() && l0_log[i] !== word(ea)) e2++;
    end
    chk({nm, "_act_addr_err"}, e1, 0);
    chk({nm, "_l0_data_err"}, e2, 0);
    chk({nm, "_psum_cnt"}, pa_log.size(), n);
    for (int i = 0; i < pa_log.size(); i++) begin
      if (pa_log[i] !== pb + 11'(i)) e3++;
      if (pd_log[i] !== prow(i)) e3++;
    end
    chk({nm, "_psum_err"}, e3, 0);
    foreach (inst_log[i]) if (inst_log[i] == 34'h9) kl++;
    chk({nm, "_kload_cycles"}, kl, 8);
    chk({nm, "_exec_cycles"}, exec_seen, n);
    chk({nm, "_done_pulses"}, done_cnt, 1);
    chk({nm, "_bad_inst_bits"}, bad_inst, 0);
    chk({nm, "_wen_vs_ofrd"}, wen_bad, 0);
    if (eb != 0) chk({nm, "_busy_cycles"}, busy_cnt, eb);
  endtask

  typedef struct {
    logic [6:0]  n;
    logic [10:0] wb, xb, pb;
    bit          gp;
    int          eb;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int k, v1, v2;
    tbl[0] = '{7'd4, 11'h010, 11'h020, 11'h100, 1'b1, 0};
    tbl[1] = '{7'd4, 11'h010, 11'h7FE, 11'h100, 1'b0, 37};
    tbl[2] = '{7'd0, 11'h3F0, 11'h400, 11'h500, 1'b0, 26};
    tbl[3] = '{7'd1, 11'h7FC, 11'h050, 11'h7FF, 1'b0, 31};
    tbl[4] = '{7'd7, 11'h200, 11'h300, 11'h7FD, 1'b1, 0};

    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 128'(busy), 0);
    chk("rst_done", 128'(done), 0);
    chk("rst_act", {act_en, act_addr, act_rdata[0]} & 13'h1FFE, 0);
    chk("rst_inst", inst_q, 0);
    chk("rst_l0", l0_input, 0);
    chk("rst_psum", {psum_wen, psum_addr}, 0);
    chk("rst_wdata", psum_wdata, 0);
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      gap = tbl[i].gp;
      start_tile(tbl[i].n, tbl[i].wb, tbl[i].xb, tbl[i].pb);
      wait_done($sformatf("tile%0d", i), 3000);
      check_tile($sformatf("tile%0d", i), int'(tbl[i].n),
                 tbl[i].wb, tbl[i].xb, tbl[i].pb, tbl[i].eb);
      if (i == 0) begin
        chk("wl_addr0", act_log[0], 11'h010);
        chk("wl_addr7", act_log[7], 11'h017);
        chk("wl_l0_0", l0_log[0][3:0], 0);
        chk("wl_l0_7", l0_log[7][3:0], 7);
        chk("wl_inst0", inst_log[0], 0);
        chk("wl_inst1", inst_log[1], 34'h4);
        chk("wl_inst8", inst_log[8], 34'h4);
        chk("wl_inst9", inst_log[9], 34'h9);
        chk("wl_inst16", inst_log[16], 34'h9);
        chk("wl_inst17", inst_log[17], 34'h0);
        chk("wl_inst24", inst_log[24], 34'h0);
      end
      if (tbl[i].xb == 11'h7FE) begin
        chk("wrap_a0", act_log[8], 11'h7FE);
        chk("wrap_a1", act_log[9], 11'h7FF);
        chk("wrap_a2", act_log[10], 11'h000);
        chk("wrap_a3", act_log[11], 11'h001);
      end
    end
    gap = 1'b0;

    // Reset abort in the middle of execute.
    start_tile(7'd4, 11'h010, 11'h020, 11'h100);
    k = 0;
    while (exec_seen == 0 && k < 500) begin
      @(negedge clk); #1;
      k++;
    end
    chk("rab_reach_exec", 128'(exec_seen > 0), 1);
    #1 reset = 1'b0;
    #1;
    chk("rab_busy", 128'(busy), 0);
    chk("rab_inst", inst_q, 0);
    chk("rab_act", {act_en, act_addr}, 0);
    chk("rab_l0", l0_input, 0);
    chk("rab_psum", {psum_wen, psum_addr}, 0);
    chk("rab_wdata", psum_wdata, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("rab_no_done", done_cnt, 0);
    @(negedge clk) reset = 1'b1;
    start_tile(7'd4, 11'h010, 11'h7FE, 11'h100);
    wait_done("rab_tile", 3000);
    check_tile("rab_tile", 4, 11'h010, 11'h7FE, 11'h100, 37);

    // Back-pressure in drain.
    hold = 1'b1;
    start_tile(7'd3, 11'h040, 11'h060, 11'h180);
    k = 0;
    while (busy_cnt < 33 && k < 500) begin
      @(negedge clk); #1;
      k++;
    end
    chk("bp_reach_drain", 128'(busy_cnt >= 33), 1);
    v1 = 0; v2 = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk); #1;
      if (psum_wen || inst_q[6]) v1++;
      if (!busy || done) v2++;
    end
    chk("bp_no_pop", v1, 0);
    chk("bp_stay_busy", v2, 0);
    chk("bp_exec_done", exec_seen, 3);
    hold = 1'b0;
    wait_done("bp", 3000);
    check_tile("bp", 3, 11'h040, 11'h060, 11'h180, 0);

    // nvec=0 tile with an ignored start pulse mid-tile.
    start_tile(7'd0, 11'h0A0, 11'h0B0, 11'h0C0);
    repeat (5) @(negedge clk);
    cfg_nvec = 7'd3; cfg_w_base = 11'h111;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("n0", 3000);
    check_tile("n0", 0, 11'h0A0, 11'h0B0, 11'h0C0, 26);
    repeat (3) @(negedge clk);
    #1;
    chk("n0_stays_idle", 128'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/corelet_ctrl.md
CORELET_CTRL -- requirements
Module: corelet_ctrl

Interface
REQ-001 Parameter: bw, 4, activation/weight element width.
REQ-002 Parameter: psum_bw, 16, partial-sum element width.
REQ-003 Parameter: row, 8, MAC rows, which is also L0 lanes.
REQ-004 Parameter: col, 8, MAC columns, which is also OFIFO lanes.
REQ-005 Parameter: aw, 11, SRAM address width.
REQ-006 Port list. One clock; reset is asynchronous and active-low.
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a tile.
- cfg_nvec  in  7  activation vectors per tile; latched at accepted start.
- cfg_w_base  in  aw  SRAM base address of the row weight vectors; latched at start.
- cfg_x_base  in  aw  SRAM base address of the activation vectors; latched at start.
- cfg_p_base  in  aw  psum SRAM base address; latched at start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the tile is complete.
- act_en  out  1  activation SRAM read enable.
- act_addr  out  aw  activation SRAM address.
- act_rdata  in  row*bw  activation SRAM data; valid 1 cycle after act_en.
- inst_q  out  34  corelet instruction word.
- l0_input  out  row*bw  corelet L0 write data.
- ofifo_valid  in  1  corelet OFIFO has a row available.
- ofifo_output  in  col*psum_bw  corelet OFIFO head row.
- psum_wen  out  1  psum SRAM write enable.
- psum_addr  out  aw  psum SRAM write address.
- psum_wdata  out  col*psum_bw  psum SRAM write data.

Function
REQ-007 inst_q bit use: [0] kernel load, [1] execute, [2] L0 wr, [3] L0 rd, [6] OFIFO rd; all other bits SHALL be 0 at all times.
REQ-008 The FSM SHALL have the states IDLE, W_FILL, W_LOAD, W_WAIT, X_FILL, X_EXEC, DRAIN, DONE; a single shared counter cnt SHALL be cleared on every state entry.
REQ-009 IDLE: start=1 SHALL latch the cfg values and go to W_FILL; start while not in IDLE SHALL be ignored.
REQ-010 W_FILL:
- cycles cnt=0..row-1: act_en=1, act_addr=w_base+cnt.
- cycles cnt=1..row: inst_q[2]=1, l0_input=act_rdata.
- exit to W_LOAD after cnt=row, so the state lasts row+1 cycles.
REQ-011 W_LOAD: inst_q[3]=1 and inst_q[0]=1 for row cycles, then go to W_WAIT.
REQ-012 W_WAIT: inst_q=0 for col cycles so weights settle; then go to X_FILL, or to DONE if nvec=0.
REQ-013 X_FILL: same timing as W_FILL with x_base and nvec in place of w_base and row; lasts nvec+1 cycles.
REQ-014 X_EXEC: inst_q[3]=1 and inst_q[1]=1 for nvec cycles, then go to DRAIN.
REQ-015 Drain handshake, active in X_EXEC and DRAIN:
- inst_q[6]=ofifo_valid while written rows < nvec.
- psum_wen=inst_q[6], psum_wdata=ofifo_output, psum_addr=p_base+written rows.
- this logic is combinational from the inputs, so a row is popped and written in the same cycle.
REQ-016 DRAIN SHALL go to DONE in the cycle after the nvec-th psum write; ofifo_valid after that SHALL NOT be popped.
REQ-017 DONE: done=1 for exactly one cycle, then go to IDLE; busy=1 in every state except IDLE.
REQ-018 All address arithmetic SHALL wrap modulo 2^aw.
REQ-019 act_en, inst_q, psum_wen SHALL be 0 in IDLE and DONE.

Reset
REQ-020 reset=0 SHALL asynchronously force state=IDLE, clear cnt, the written-row count and the latched cfg registers, and drive every output to 0.
REQ-021 reset asserted mid-tile SHALL abort the tile with no done pulse; the first start after reset release SHALL run a full tile.

Structure
REQ-022 A shared package corelet_pkg SHALL hold the FSM state enum and the named inst_q bit-position constants (KLOAD=0, EXEC=1, L0WR=2, L0RD=3, OFRD=6).
REQ-023 The block SHALL be implemented as one FSM with one shared counter; no sub-module is required.

Verification
REQ-024 Reset: reset=0 pulsed during X_EXEC -> all outputs 0 immediately; no done; a new start then completes a full tile.
REQ-025 Weight load: w_base=0x010, row=8, SRAM word i = i -> act_addr 0x010..0x017 on consecutive cycles; inst_q[2] with l0_input=0..7 one cycle later; then 8 cycles of inst_q=0x9; then 8 cycles of inst_q=0.
REQ-026 Full tile: nvec=4, p_base=0x100, OFIFO model returns rows R0..R3 with gaps -> psum writes to 0x100..0x103 carrying R0..R3 in order; a single done pulse.
REQ-027 Back-pressure: ofifo_valid held 0 for 20 cycles in DRAIN -> no psum_wen and no inst_q[6]; the FSM stays in DRAIN and busy stays 1.
REQ-028 nvec=0 -> no X_FILL, X_EXEC or DRAIN activity; done one cycle after W_WAIT ends; start pulsed mid-tile is ignored.
REQ-029 Wrap: x_base=0x7FE, nvec=4 -> act_addr sequence 0x7FE, 0x7FF, 0x000, 0x001.
